hls_deadlock_report_ctrl: RTL

HLS_DEADLOCK_REPORT_CTRL -- requirements
Module: hls_deadlock_report_ctrl

---
 rtl/hls_deadlock_report_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hls_deadlock_report_ctrl.sv
// Deadlock report controller: confirms persistent per-monitor blocking and
// hands confirmed monitors to a consumer one at a time in round-robin order.
module hls_deadlock_report_ctrl #(
  parameter int N_MON    = 4,
  parameter int THRESH_W = 8,
  parameter int IDX_W    = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic [THRESH_W-1:0] cfg_thresh,
  input  logic [N_MON-1:0]    mon_block,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [IDX_W-1:0]    rpt_idx,
  output logic [N_MON-1:0]    pending_vec,
  output logic                deadlock
);

  typedef enum logic {IDLE, REPORT} state_t;

  state_t              state, state_next;
  logic [THRESH_W-1:0] cnt [N_MON];
  logic [N_MON-1:0]    armed;
  logic [N_MON-1:0]    confirm;
  logic [THRESH_W-1:0] thresh_m1;
  logic [IDX_W-1:0]    rr_ptr, rr_next, idx_next, sel_idx;
  logic                found;
  logic [N_MON-1:0]    ack_mask;
  logic [N_MON-1:0]    pend_rot;
  logic [IDX_W:0]      pos;

  // A zero threshold behaves like one; confirmation fires on the T-1 -> T step.
  assign thresh_m1 = (cfg_thresh == '0) ? '0 : cfg_thresh - THRESH_W'(1);

  always_comb begin
    confirm = '0;
    for (int i = 0; i < N_MON; i++) begin
      confirm[i] = enable && mon_block[i] && armed[i] && (cnt[i] == thresh_m1);
    end
  end

  // armed drops at confirmation and only a low mon_block sample restores it,
  // so a counter that passes T again after a threshold change cannot re-fire.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      for (int i = 0; i < N_MON; i++) begin
        cnt[i] <= '0;
      end
      armed <= '1;
    end else begin
      for (int i = 0; i < N_MON; i++) begin
        if (!enable || !mon_block[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] != '1) begin
          cnt[i] <= cnt[i] + THRESH_W'(1);
        end
        if (!mon_block[i]) begin
          armed[i] <= 1'b1;
        end else if (confirm[i]) begin
          armed[i] <= 1'b0;
        end
      end
    end
  end

  // Rotate pending bits so bit 0 corresponds to rr_ptr, then take the lowest set bit.
  assign pend_rot = N_MON'({pending_vec, pending_vec} >> rr_ptr);

  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    pos     = '0;
    for (int k = N_MON - 1; k >= 0; k--) begin
      if (pend_rot[k]) begin
        found = 1'b1;
        pos   = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
        if (pos >= (IDX_W + 1)'(N_MON)) begin
          pos = pos - (IDX_W + 1)'(N_MON);
        end
        sel_idx = pos[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = rpt_idx;
    rr_next    = rr_ptr;
    ack_mask   = '0;
    case (state)
      IDLE: begin
        if (found) begin
          idx_next   = sel_idx;
          state_next = REPORT;
        end
      end
      REPORT: begin
        if (rpt_ready) begin
          ack_mask   = N_MON'(1) << rpt_idx;
          rr_next    = (rpt_idx == IDX_W'(N_MON - 1)) ? '0 : rpt_idx + IDX_W'(1);
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A confirmation landing on the index being acknowledged survives (set wins).
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state       <= IDLE;
      rpt_idx     <= '0;
      rr_ptr      <= '0;
      pending_vec <= '0;
      deadlock    <= 1'b0;
    end else begin
      state       <= state_next;
      rpt_idx     <= idx_next;
      rr_ptr      <= rr_next;
      pending_vec <= (pending_vec & ~ack_mask) | confirm;
      deadlock    <= deadlock | (|confirm);
    end
  end

  assign rpt_valid = (state == REPORT);

endmodule
